// File: rtl/dmem_responder.sv
// Data-memory responder: 128-word array fronted by a FIFO write buffer with
// load forwarding. Define DMEM_ALIGN_CHK_EN to enable misaligned-access detection.
module dmem_responder #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 9,
   parameter int BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic              rd,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              stall,
   output logic              buf_empty,
   output logic              misalign,
   output logic [15:0]       wr_cnt,
   output logic [15:0]       rd_cnt
);
   localparam int IDX_W = ADDR_W - 2;
   localparam int WORDS = 1 << IDX_W;
   localparam int PW    = $clog2(BUF_DEPTH);
   localparam int CW    = PW + 1;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   logic [DATA_W-1:0] mem [WORDS];
   wb_entry_t         buf_q [BUF_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [IDX_W-1:0]  req_idx;
   logic              bad, full, drain, push;
   logic              hit;
   logic [DATA_W-1:0] fwd;

   assign req_idx = addr[ADDR_W-1:2];

`ifdef DMEM_ALIGN_CHK_EN
   assign bad = (rd | wr) && (addr[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (reset) misalign <= 1'b0;
      else       misalign <= bad;
   end
`else
   logic unused_addr_lo;
   assign unused_addr_lo = ^addr[1:0];
   assign bad            = 1'b0;
   assign misalign       = 1'b0;
`endif

   // A load owns the single array port, so draining only happens when rd=0.
   assign full      = (count == CW'(BUF_DEPTH));
   assign drain     = !reset && !rd && (count != '0);
   assign push      = !reset && wr && !bad && (!full || drain);
   assign stall     = !reset && wr && !bad && full && rd;
   assign buf_empty = (count == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + 1'b1;
         if (drain) rd_ptr <= rd_ptr + 1'b1;
         case ({push, drain})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         wr_cnt <= wr_cnt + 16'(push);
         rd_cnt <= rd_cnt + 16'(rd && !bad);
      end
   end

   always_ff @(posedge clk) begin
      if (push) buf_q[wr_ptr] <= '{idx: req_idx, data: wr_data};
   end

   always_ff @(posedge clk) begin
      if (drain) mem[buf_q[rd_ptr].idx] <= buf_q[rd_ptr].data;
   end

   // Walk oldest to youngest so the last match is the youngest store.
   always_comb begin
      logic [PW-1:0] slot;
      slot    = '0;
      hit     = 1'b0;
      fwd     = '0;
      rd_data = '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
         slot = rd_ptr + PW'(i);
         if ((CW'(i) < count) && (buf_q[slot].idx == req_idx)) begin
            hit = 1'b1;
            fwd = buf_q[slot].data;
         end
      end
      if (rd && !bad) rd_data = hit ? fwd : mem[req_idx];
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected rd_data queued at drive time,
// popped on the falling edge; scenario tasks check control outputs inline.
module tb_dmem_responder;
   logic        clk = 1'b0;
   logic        reset, wr, rd;
   logic [8:0]  addr;
   logic [31:0] wr_data, rd_data;
   logic        stall, buf_empty, misalign;
   logic [15:0] wr_cnt, rd_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [6:0]  idx;
      logic [31:0] data;
   } ent_t;

   ent_t        pend[$];
   logic [31:0] dmem_m [128];
   logic [31:0] exp_q[$];

   dmem_responder dut (
      .clk(clk), .reset(reset), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
      .rd_data(rd_data), .stall(stall), .buf_empty(buf_empty), .misalign(misalign),
      .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Scoreboard: one expected rd_data per driven cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         checks++;
         if (rd_data !== e) begin
            errors++;
            $display("FAIL rd_data addr=%h: got %h want %h", addr, rd_data, e);
         end
      end
   end

   function automatic bit bad_of(input logic w, input logic r, input logic [8:0] a);
`ifdef DMEM_ALIGN_CHK_EN
      return (w | r) && (a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] view(input logic [6:0] idx);
      for (int i = pend.size() - 1; i >= 0; i--)
         if (pend[i].idx == idx) return pend[i].data;
      return dmem_m[idx];
   endfunction

   task automatic drive(input logic w, input logic r, input logic [8:0] a, input logic [31:0] d);
      wr = w; rd = r; addr = a; wr_data = d;
      if (!reset) exp_q.push_back((r && !bad_of(w, r, a)) ? view(a[8:2]) : 32'h0);
   endtask

   // Advance one clock and update the reference model with this cycle's inputs.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         pend.delete();
      end else begin
         bit b, dr, pu;
         ent_t e;
         b  = bad_of(wr, rd, addr);
         dr = !rd && (pend.size() > 0);
         pu = wr && !b && ((pend.size() < 4) || dr);
         if (dr) begin
            e = pend.pop_front();
            dmem_m[e.idx] = e.data;
         end
         if (pu) pend.push_back('{addr[8:2], wr_data});
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 9'h0, 32'h0);
         tick();
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0;
      tick(); tick();
      reset = 1'b0;
      checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL reset_buf_empty: got %b want 1", buf_empty); end
      checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt); end
      checks++; if (rd_cnt !== 16'd0) begin errors++; $display("FAIL reset_rd_cnt: got %0d want 0", rd_cnt); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
   endtask

   // Fill every word with a known pattern; pointers wrap many times here.
   task automatic prime();
      for (int i = 0; i < 128; i++) begin
         drive(1'b1, 1'b0, 9'(i * 4), 32'hC0DE_0000 + 32'(i));
         tick();
      end
      idle(6);
      checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL prime_drained: got %b want 1", buf_empty); end
   endtask

   task automatic test_forward();
      pulse_reset();
      drive(1'b1, 1'b0, 9'h010, 32'hDEADBEEF); tick();
      drive(1'b0, 1'b1, 9'h010, 32'h0);
      @(negedge clk); #1;
      checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL fwd_data: got %h want deadbeef", rd_data); end
      checks++; if (buf_empty !== 1'b0) begin errors++; $display("FAIL fwd_buf_empty: got %b want 0", buf_empty); end
      tick();
      idle(2);
   endtask

   task automatic test_stall();
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 9'h100 + 9'(i * 4), 32'h5000 + 32'(i));
         @(negedge clk); #1;
         checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall%0d: got %b want 0", i, stall); end
         tick();
      end
      drive(1'b1, 1'b1, 9'h110, 32'h5004);
      @(negedge clk); #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", stall); end
      tick();
      checks++; if (wr_cnt !== 16'd4) begin errors++; $display("FAIL stall_wr_cnt: got %0d want 4", wr_cnt); end
      drive(1'b1, 1'b0, 9'h110, 32'h5004);
      @(negedge clk); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL drain_accept_stall: got %b want 0", stall); end
      tick();
      checks++; if (wr_cnt !== 16'd5) begin errors++; $display("FAIL accept_wr_cnt: got %0d want 5", wr_cnt); end
      // Still full: push and drain together kept count at 4.
      drive(1'b1, 1'b1, 9'h114, 32'h5005);
      @(negedge clk); #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL still_full_stall: got %b want 1", stall); end
      tick();
      checks++; if (rd_cnt !== 16'd6) begin errors++; $display("FAIL stall_rd_cnt: got %0d want 6", rd_cnt); end
      idle(5);
      checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL stall_drained: got %b want 1", buf_empty); end
   endtask

   task automatic test_rw_same_cycle();
      drive(1'b1, 1'b0, 9'h020, 32'h11); tick();
      idle(2);
      drive(1'b1, 1'b1, 9'h020, 32'h22);
      @(negedge clk); #1;
      checks++; if (rd_data !== 32'h11) begin errors++; $display("FAIL rw_same_old: got %h want 11", rd_data); end
      tick();
      drive(1'b0, 1'b1, 9'h020, 32'h0);
      @(negedge clk); #1;
      checks++; if (rd_data !== 32'h22) begin errors++; $display("FAIL rw_same_new: got %h want 22", rd_data); end
      tick();
      idle(2);
   endtask

   task automatic test_same_addr();
      drive(1'b1, 1'b1, 9'h044, 32'hA); tick();
      drive(1'b1, 1'b1, 9'h044, 32'hB); tick();
      drive(1'b0, 1'b1, 9'h044, 32'h0);
      @(negedge clk); #1;
      checks++; if (rd_data !== 32'hB) begin errors++; $display("FAIL youngest_fwd: got %h want b", rd_data); end
      tick();
      idle(3);
      checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL same_addr_empty: got %b want 1", buf_empty); end
      drive(1'b0, 1'b1, 9'h044, 32'h0);
      @(negedge clk); #1;
      checks++; if (rd_data !== 32'hB) begin errors++; $display("FAIL same_addr_array: got %h want b", rd_data); end
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 9'h080 + 9'(i * 4), 32'h7700 + 32'(i)); tick();
      end
      checks++; if (wr_cnt === 16'd0) begin errors++; $display("FAIL mid_pre_wr_cnt: got %0d want nonzero", wr_cnt); end
      reset = 1'b1; wr = 1'b1; rd = 1'b1; addr = 9'h08C; wr_data = 32'h7703;
      @(negedge clk); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall: got %b want 0", stall); end
      tick();
      reset = 1'b0;
      checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL mid_buf_empty: got %b want 1", buf_empty); end
      checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL mid_wr_cnt: got %0d want 0", wr_cnt); end
      checks++; if (rd_cnt !== 16'd0) begin errors++; $display("FAIL mid_rd_cnt: got %0d want 0", rd_cnt); end
      drive(1'b0, 1'b1, 9'h080, 32'h0);
      @(negedge clk); #1;
      checks++; if (rd_data !== 32'hC0DE_0020) begin errors++; $display("FAIL mid_discard: got %h want c0de0020", rd_data); end
      tick();
      for (int i = 1; i < 4; i++) begin
         drive(1'b0, 1'b1, 9'h080 + 9'(i * 4), 32'h0); tick();
      end
      // Full buffer with wr+rd during reset must not stall or push.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 9'h0C0 + 9'(i * 4), 32'h9900 + 32'(i)); tick();
      end
      reset = 1'b1; wr = 1'b1; rd = 1'b1; addr = 9'h0D0; wr_data = 32'h9904;
      @(negedge clk); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_reset_stall: got %b want 0", stall); end
      tick();
      reset = 1'b0;
      checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL full_reset_empty: got %b want 1", buf_empty); end
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 9'h0C0 + 9'(i * 4), 32'h0); tick();
      end
   endtask

   task automatic test_align();
      pulse_reset();
`ifdef DMEM_ALIGN_CHK_EN
      drive(1'b1, 1'b0, 9'h013, 32'h55); tick();
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL align_flag: got %b want 1", misalign); end
      checks++; if (wr_cnt !== 16'd0) begin errors++; $display("FAIL align_wr_cnt: got %0d want 0", wr_cnt); end
      checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL align_no_push: got %b want 1", buf_empty); end
      drive(1'b0, 1'b1, 9'h012, 32'h0); tick();
      checks++; if (rd_cnt !== 16'd0) begin errors++; $display("FAIL align_rd_cnt: got %0d want 0", rd_cnt); end
      idle(1);
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL align_clear: got %b want 0", misalign); end
`else
      drive(1'b1, 1'b0, 9'h013, 32'h55); tick();
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL align_tied: got %b want 0", misalign); end
      checks++; if (wr_cnt !== 16'd1) begin errors++; $display("FAIL align_wr_cnt: got %0d want 1", wr_cnt); end
      drive(1'b0, 1'b1, 9'h010, 32'h0);
      @(negedge clk); #1;
      checks++; if (rd_data !== 32'h55) begin errors++; $display("FAIL align_word4: got %h want 55", rd_data); end
      tick();
`endif
      idle(3);
   endtask

   initial begin
      reset = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0;
      test_reset();
      prime();
      test_forward();
      test_stall();
      test_rw_same_cycle();
      test_same_addr();
      test_reset_mid();
      test_align();
      idle(2);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
